jtag_cmd_executor: RTL and testbench
====================================

Name: jtag_cmd_executor

Overview:
- Downstream consumer of the two-register JTAG interface wrapper. It takes the host-written command and write-data words and executes them as single read/write transfers on an on-chip valid/ready register bus.
- It returns status and read data to the wrapper's host-readable inputs, so the host can poll completion over JTAG.
- Intended wiring: iCMD from oDATA_0, iWDATA from oDATA_1, oSTATUS to iDATA_0, oRDATA to iDATA_1.

Parameters:
- WIDTH, 32: width of the JTAG registers and bus data. Must satisfy WIDTH >= ADDR_WIDTH+12.
- ADDR_WIDTH, 16: bus address width.
- STABLE_CYCLES, 4: consecutive identical synchronized samples required before a command is accepted (>=1).
- TIMEOUT_CYCLES, 1024: bus wait cycles before a transfer is abandoned (>=1).

Ports:
- iMAIN_CLK  in  1  system clock.
- iRESET_N  in  1  asynchronous active-low reset.
- iCMD  in  WIDTH  command word. Bit WIDTH-1 = TAG, bit WIDTH-2 = WRITE (1 = write, 0 = read), [ADDR_WIDTH-1:0] = address, other bits ignored.
- iWDATA  in  WIDTH  write data.
- oSTATUS  out  WIDTH  status word. WIDTH-1 = last completed TAG, WIDTH-2 = BUSY, WIDTH-3 = TIMEOUT, WIDTH-4 = BUS_ERR, [WIDTH-5:WIDTH-12] = 8-bit completion count, [ADDR_WIDTH-1:0] = last completed address, other bits 0.
- oRDATA  out  WIDTH  data from the last successful read.
- oBUS_VALID  out  1  transfer request.
- oBUS_WRITE  out  1  transfer direction.
- oBUS_ADDR  out  ADDR_WIDTH  transfer address.
- oBUS_WDATA  out  WIDTH  transfer write data.
- iBUS_READY  in  1  slave accepts/completes the transfer.
- iBUS_RDATA  in  WIDTH  read data, valid while iBUS_READY is high.
- iBUS_ERR  in  1  slave error, sampled with iBUS_READY.

Behaviour:
- Reset (asynchronous, takes effect immediately): all outputs 0, last_tag = 0, state IDLE, synchronizers cleared.
- Input capture: iCMD and iWDATA each pass through a two-flop register stage, giving cmd_s and wdata_s. They are treated as quasi-static, since JTAG updates may land mid-word.
- IDLE:
  - When cmd_s TAG != last_tag: snapshot {cmd_s, wdata_s}, clear the stability counter, set BUSY, go to SETTLE.
  - Otherwise remain in IDLE; outputs hold.
- SETTLE:
  - Each cycle, compare {cmd_s, wdata_s} with the snapshot.
  - On mismatch: re-snapshot and clear the counter.
  - On match: increment the counter.
  - When STABLE_CYCLES consecutive matches have occurred: latch WRITE, address and data onto the bus outputs, assert oBUS_VALID, go to REQ.
  - If cmd_s TAG returns to last_tag while in SETTLE: clear BUSY and return to IDLE with no transfer.
- Latency: with stable inputs, oBUS_VALID rises on the (STABLE_CYCLES+3)th rising edge after iCMD changes. Default: 7.
- REQ:
  - oBUS_VALID, WRITE, ADDR and WDATA are held constant until completion.
  - A transfer completes on an edge where oBUS_VALID && iBUS_READY.
  - The wait counter increments on each REQ cycle without iBUS_READY.
- Completion by handshake, all on the same edge:
  - oBUS_VALID <= 0.
  - On a read with iBUS_ERR = 0: oRDATA <= iBUS_RDATA.
  - On a write, or on error: oRDATA is unchanged.
  - BUS_ERR <= iBUS_ERR; TIMEOUT <= 0.
  - Status TAG <= accepted tag; last_tag <= accepted tag.
  - Address field <= accepted address.
  - Count increments, wrapping 255 -> 0.
  - BUSY <= 0; state -> IDLE.
- Completion by timeout: after TIMEOUT_CYCLES cycles in REQ without iBUS_READY, perform the same completion with TIMEOUT <= 1, BUS_ERR <= 0 and oRDATA unchanged. A late iBUS_READY is ignored.
- iCMD changes during REQ are ignored. Re-evaluation starts in IDLE on the next cycle. A double toggle (TAG back to last_tag) produces no new command.
- The IDLE -> SETTLE check may fire on the cycle immediately after completion. No idle gap is guaranteed.
- Reset asserted during REQ drops oBUS_VALID immediately. The transfer is lost and no status is reported.
- Post-reset, an iCMD with TAG = 0 is never executed. The host must toggle TAG to 1 for its first command.

Test Plan:
- Read: iCMD = 0x8000_0012 held, slave returns READY one cycle after VALID with RDATA = 0xDEADBEEF -> VALID at edge 7 after the change; oRDATA = 0xDEADBEEF; oSTATUS = 0x8010_0012 (TAG 1, count 1, addr 0x0012, BUSY 0).
- Write: iCMD = 0x4000_0034 (TAG 0, WRITE 1) after the read above, iWDATA = 0x1234_5678 -> one bus write to addr 0x34 with WDATA 0x12345678; oRDATA unchanged; oSTATUS TAG 0, count 2.
- Glitchy update: iCMD toggles between 0x8000_0001 and 0x8000_0002 every 2 cycles for 20 cycles, then settles at 0x8000_0002 -> no VALID during toggling; exactly one transfer to addr 0x0002.
- Timeout with TIMEOUT_CYCLES = 8, iBUS_READY held 0 -> VALID high exactly 8 cycles then drops; TIMEOUT = 1; BUS_ERR = 0; TAG and count updated.
- Bus error: read with READY = 1 and iBUS_ERR = 1 -> BUS_ERR = 1; oRDATA keeps its previous value; the next good command clears BUS_ERR.
- Reset mid-REQ: iRESET_N low while VALID is high -> VALID = 0 immediately and all outputs 0. After release, with iCMD held at TAG 0, no transfer occurs.
- Count wrap: 256 commands with alternating TAG -> count reads 0.

Source files
------------

// File: rtl/jtag_cmd_executor.sv
// jtag_cmd_executor: executes host-written JTAG command/write-data words as
// single read/write transfers on a valid/ready register bus, and reports
// status and read data back to the host-readable JTAG registers.
module jtag_cmd_executor #(
    parameter int WIDTH          = 32,
    parameter int ADDR_WIDTH     = 16,
    parameter int STABLE_CYCLES  = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                  iMAIN_CLK,
    input  logic                  iRESET_N,
    input  logic [WIDTH-1:0]      iCMD,
    input  logic [WIDTH-1:0]      iWDATA,
    output logic [WIDTH-1:0]      oSTATUS,
    output logic [WIDTH-1:0]      oRDATA,
    output logic                  oBUS_VALID,
    output logic                  oBUS_WRITE,
    output logic [ADDR_WIDTH-1:0] oBUS_ADDR,
    output logic [WIDTH-1:0]      oBUS_WDATA,
    input  logic                  iBUS_READY,
    input  logic [WIDTH-1:0]      iBUS_RDATA,
    input  logic                  iBUS_ERR
);

    localparam int SC_W = $clog2(STABLE_CYCLES + 1);
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [SC_W-1:0] SC_LAST = SC_W'(STABLE_CYCLES - 1);
    localparam logic [SC_W-1:0] SC_ONE  = SC_W'(1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [TO_W-1:0] TO_ONE  = TO_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_REQ    = 2'd2
    } state_t;

    // Two-flop capture of the quasi-static JTAG words
    logic [WIDTH-1:0] r_cmd_m;
    logic [WIDTH-1:0] r_cmd_s;
    logic [WIDTH-1:0] r_wdata_m;
    logic [WIDTH-1:0] r_wdata_s;

    // Command acceptance and bus control state
    state_t            r_state;
    logic [WIDTH-1:0]  r_snap_cmd;
    logic [WIDTH-1:0]  r_snap_wdata;
    logic [SC_W-1:0]   r_stable_cnt;
    logic [TO_W-1:0]   r_wait_cnt;
    logic              r_bus_valid;
    logic              r_bus_write;
    logic [ADDR_WIDTH-1:0] r_bus_addr;
    logic [WIDTH-1:0]  r_bus_wdata;

    // Host-visible status fields; the last completed tag doubles as the
    // reference against which new commands are detected
    logic              r_last_tag;
    logic              r_busy;
    logic              r_timeout;
    logic              r_bus_err;
    logic [7:0]        r_count;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [WIDTH-1:0]  r_rdata;

    logic [WIDTH-1:0]  w_status;

    // Capture JTAG command and write data through a two-register stage
    always_ff @(posedge iMAIN_CLK or negedge iRESET_N) begin
        if (!iRESET_N) begin
            r_cmd_m   <= '0;
            r_cmd_s   <= '0;
            r_wdata_m <= '0;
            r_wdata_s <= '0;
        end else begin
            r_cmd_m   <= iCMD;
            r_cmd_s   <= r_cmd_m;
            r_wdata_m <= iWDATA;
            r_wdata_s <= r_wdata_m;
        end
    end

    // Command FSM: detect tag toggle, wait for stable words, run one transfer
    always_ff @(posedge iMAIN_CLK or negedge iRESET_N) begin
        if (!iRESET_N) begin
            r_state      <= ST_IDLE;
            r_snap_cmd   <= '0;
            r_snap_wdata <= '0;
            r_stable_cnt <= '0;
            r_wait_cnt   <= '0;
            r_bus_valid  <= 1'b0;
            r_bus_write  <= 1'b0;
            r_bus_addr   <= '0;
            r_bus_wdata  <= '0;
            r_last_tag   <= 1'b0;
            r_busy       <= 1'b0;
            r_timeout    <= 1'b0;
            r_bus_err    <= 1'b0;
            r_count      <= 8'd0;
            r_addr       <= '0;
            r_rdata      <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (r_cmd_s[WIDTH-1] != r_last_tag) begin
                        r_snap_cmd   <= r_cmd_s;
                        r_snap_wdata <= r_wdata_s;
                        r_stable_cnt <= '0;
                        r_busy       <= 1'b1;
                        r_state      <= ST_SETTLE;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_SETTLE: begin
                    if (r_cmd_s[WIDTH-1] == r_last_tag) begin
                        // Host withdrew the command before it settled
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end else if ({r_cmd_s, r_wdata_s} != {r_snap_cmd, r_snap_wdata}) begin
                        r_snap_cmd   <= r_cmd_s;
                        r_snap_wdata <= r_wdata_s;
                        r_stable_cnt <= '0;
                    end else if (r_stable_cnt == SC_LAST) begin
                        r_bus_write <= r_snap_cmd[WIDTH-2];
                        r_bus_addr  <= r_snap_cmd[ADDR_WIDTH-1:0];
                        r_bus_wdata <= r_snap_wdata;
                        r_bus_valid <= 1'b1;
                        r_wait_cnt  <= '0;
                        r_state     <= ST_REQ;
                    end else begin
                        r_stable_cnt <= r_stable_cnt + SC_ONE;
                    end
                end
                ST_REQ: begin
                    if (iBUS_READY) begin
                        // Handshake completion; read data only kept on a clean read
                        if (!r_bus_write && !iBUS_ERR) begin
                            r_rdata <= iBUS_RDATA;
                        end else begin
                            r_rdata <= r_rdata;
                        end
                        r_bus_valid <= 1'b0;
                        r_bus_err   <= iBUS_ERR;
                        r_timeout   <= 1'b0;
                        r_last_tag  <= r_snap_cmd[WIDTH-1];
                        r_addr      <= r_bus_addr;
                        r_count     <= r_count + 8'd1;
                        r_busy      <= 1'b0;
                        r_state     <= ST_IDLE;
                    end else if (r_wait_cnt == TO_LAST) begin
                        // Slave never answered; abandon the transfer
                        r_bus_valid <= 1'b0;
                        r_bus_err   <= 1'b0;
                        r_timeout   <= 1'b1;
                        r_last_tag  <= r_snap_cmd[WIDTH-1];
                        r_addr      <= r_bus_addr;
                        r_count     <= r_count + 8'd1;
                        r_busy      <= 1'b0;
                        r_state     <= ST_IDLE;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + TO_ONE;
                    end
                end
                default: begin
                    r_bus_valid <= 1'b0;
                    r_busy      <= 1'b0;
                    r_state     <= ST_IDLE;
                end
            endcase
        end
    end

    // Pack status fields into the host-readable status word
    always_comb begin
        w_status                   = '0;
        w_status[WIDTH-1]          = r_last_tag;
        w_status[WIDTH-2]          = r_busy;
        w_status[WIDTH-3]          = r_timeout;
        w_status[WIDTH-4]          = r_bus_err;
        w_status[WIDTH-5 -: 8]     = r_count;
        w_status[ADDR_WIDTH-1:0]   = r_addr;
    end

    assign oSTATUS    = w_status;
    assign oRDATA     = r_rdata;
    assign oBUS_VALID = r_bus_valid;
    assign oBUS_WRITE = r_bus_write;
    assign oBUS_ADDR  = r_bus_addr;
    assign oBUS_WDATA = r_bus_wdata;

endmodule

// File: tb/tb_jtag_cmd_executor.sv
// tb_jtag_cmd_executor: directed bench with a bus-transfer scoreboard and a
// reference model of the status/read-data registers.
module tb_jtag_cmd_executor;

    localparam int WIDTH = 32;
    localparam int AW    = 16;
    localparam int SC    = 4;
    localparam int TO    = 8;

    logic              iMAIN_CLK = 1'b0;
    logic              iRESET_N  = 1'b0;
    logic [WIDTH-1:0]  iCMD      = '0;
    logic [WIDTH-1:0]  iWDATA    = '0;
    logic [WIDTH-1:0]  oSTATUS;
    logic [WIDTH-1:0]  oRDATA;
    logic              oBUS_VALID;
    logic              oBUS_WRITE;
    logic [AW-1:0]     oBUS_ADDR;
    logic [WIDTH-1:0]  oBUS_WDATA;
    logic              iBUS_READY = 1'b0;
    logic [WIDTH-1:0]  iBUS_RDATA = '0;
    logic              iBUS_ERR   = 1'b0;

    jtag_cmd_executor #(
        .WIDTH(WIDTH), .ADDR_WIDTH(AW), .STABLE_CYCLES(SC), .TIMEOUT_CYCLES(TO)
    ) dut (
        .iMAIN_CLK(iMAIN_CLK), .iRESET_N(iRESET_N), .iCMD(iCMD), .iWDATA(iWDATA),
        .oSTATUS(oSTATUS), .oRDATA(oRDATA), .oBUS_VALID(oBUS_VALID),
        .oBUS_WRITE(oBUS_WRITE), .oBUS_ADDR(oBUS_ADDR), .oBUS_WDATA(oBUS_WDATA),
        .iBUS_READY(iBUS_READY), .iBUS_RDATA(iBUS_RDATA), .iBUS_ERR(iBUS_ERR)
    );

    always #5 iMAIN_CLK = ~iMAIN_CLK;

    typedef struct packed {
        logic            write;
        logic [AW-1:0]   addr;
        logic [WIDTH-1:0] wdata;
    } xfer_t;

    xfer_t sb_q[$];
    int checks = 0;
    int errors = 0;
    int n_req  = 0;
    logic prev_v = 1'b0;

    // Reference model of host-visible state
    logic             m_tag = 1'b0;
    logic             m_to  = 1'b0;
    logic             m_err = 1'b0;
    logic [7:0]       m_cnt = 8'd0;
    logic [AW-1:0]    m_addr = '0;
    logic [WIDTH-1:0] m_rdata = '0;

    // Count bus requests (rising edges of VALID), sampled away from the active edge
    always @(negedge iMAIN_CLK) begin
        if (oBUS_VALID && !prev_v) n_req = n_req + 1;
        prev_v = oBUS_VALID;
    end

    function automatic logic [WIDTH-1:0] exp_status(input logic busy);
        logic [WIDTH-1:0] s;
        s = '0;
        s[WIDTH-1] = m_tag;
        s[WIDTH-2] = busy;
        s[WIDTH-3] = m_to;
        s[WIDTH-4] = m_err;
        s[WIDTH-5 -: 8] = m_cnt;
        s[AW-1:0] = m_addr;
        return s;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge iMAIN_CLK);
        #1;
    endtask

    task automatic drive_cmd(input logic [WIDTH-1:0] cmd, input logic [WIDTH-1:0] wd);
        xfer_t x;
        iCMD   = cmd;
        iWDATA = wd;
        x.write = cmd[WIDTH-2];
        x.addr  = cmd[AW-1:0];
        x.wdata = wd;
        sb_q.push_back(x);
    endtask

    // Wait (bounded) for VALID, then compare the request with the scoreboard
    task automatic wait_valid(input int exp_lat);
        int lat;
        xfer_t e;
        lat = 0;
        for (int n = 1; n <= 100; n++) begin
            tick();
            if (oBUS_VALID) begin
                lat = n;
                break;
            end
        end
        check("valid_seen", oBUS_VALID, 1);
        if (exp_lat > 0) check("latency", lat, exp_lat);
        if (sb_q.size() == 0) begin
            errors++;
            $error("FAIL sb_underflow: observed empty queue required one entry");
        end else begin
            e = sb_q.pop_front();
            check("bus_xfer", {oBUS_WRITE, oBUS_ADDR, oBUS_WDATA}, e);
        end
        check("status_busy", oSTATUS, exp_status(1'b1));
    endtask

    // Complete the outstanding request (d<0: never answer) and check results
    task automatic finish_xfer(input logic [WIDTH-1:0] cmd, input int d,
                               input logic err, input logic [WIDTH-1:0] rd);
        if (d < 0) begin
            int k;
            k = 0;
            for (int n = 1; n <= 40; n++) begin
                tick();
                if (!oBUS_VALID) begin
                    k = n;
                    break;
                end
            end
            check("timeout_len", k, TO);
            m_to  = 1'b1;
            m_err = 1'b0;
        end else begin
            for (int n = 0; n < d; n++) tick();
            check("valid_hold", oBUS_VALID, 1);
            iBUS_READY = 1'b1;
            iBUS_ERR   = err;
            iBUS_RDATA = rd;
            tick();
            iBUS_READY = 1'b0;
            iBUS_ERR   = 1'b0;
            iBUS_RDATA = '0;
            check("valid_drop", oBUS_VALID, 0);
            m_to  = 1'b0;
            m_err = err;
            if (!cmd[WIDTH-2] && !err) m_rdata = rd;
        end
        m_tag  = cmd[WIDTH-1];
        m_cnt  = m_cnt + 8'd1;
        m_addr = cmd[AW-1:0];
        check("rdata", oRDATA, m_rdata);
        check("status", oSTATUS, exp_status(1'b0));
    endtask

    initial begin
        int nb;
        logic [WIDTH-1:0] c;

        // Reset state
        #3;
        check("rst_status", oSTATUS, 0);
        check("rst_rdata", oRDATA, 0);
        check("rst_valid", oBUS_VALID, 0);
        tick(); tick();
        iRESET_N = 1'b1;

        // TAG 0 after reset is never executed
        nb = n_req;
        for (int n = 0; n < 20; n++) tick();
        check("no_xfer_tag0", n_req, nb);

        // Read with one-cycle slave latency
        drive_cmd(32'h8000_0012, 32'h0000_0000);
        wait_valid(7);
        finish_xfer(32'h8000_0012, 1, 1'b0, 32'hDEAD_BEEF);
        check("read_status_lit", oSTATUS, 32'h8010_0012);

        // Write
        drive_cmd(32'h4000_0034, 32'h1234_5678);
        wait_valid(7);
        finish_xfer(32'h4000_0034, 1, 1'b0, 32'hCAFE_0000);
        check("write_status_lit", oSTATUS, 32'h0020_0034);

        // Glitchy update: toggle every 2 cycles, then settle
        nb = n_req;
        for (int i = 0; i < 10; i++) begin
            iCMD = (i % 2 == 0) ? 32'h8000_0001 : 32'h8000_0002;
            tick(); tick();
        end
        check("glitch_no_valid", n_req, nb);
        drive_cmd(32'h8000_0002, 32'h1234_5678);
        wait_valid(0);
        finish_xfer(32'h8000_0002, 0, 1'b0, 32'h0BAD_F00D);
        check("glitch_one_xfer", n_req, nb + 1);

        // Timeout, then a late READY that must be ignored
        drive_cmd(32'h0000_0005, 32'h1234_5678);
        wait_valid(7);
        finish_xfer(32'h0000_0005, -1, 1'b0, 32'h0);
        iBUS_READY = 1'b1;
        iBUS_RDATA = 32'hAAAA_5555;
        tick();
        iBUS_READY = 1'b0;
        tick();
        check("late_ready_rdata", oRDATA, m_rdata);
        check("late_ready_status", oSTATUS, exp_status(1'b0));

        // Bus error on read, then a good write clears it
        drive_cmd(32'h8000_0077, 32'h1234_5678);
        wait_valid(7);
        finish_xfer(32'h8000_0077, 0, 1'b1, 32'hFFFF_FFFF);
        drive_cmd(32'h4000_0078, 32'h0F0F_0F0F);
        wait_valid(7);
        finish_xfer(32'h4000_0078, 2, 1'b0, 32'h0);

        // Reset while the request is outstanding
        drive_cmd(32'h8000_0099, 32'h0F0F_0F0F);
        wait_valid(7);
        #2;
        iRESET_N = 1'b0;
        #1;
        check("rstreq_valid", oBUS_VALID, 0);
        check("rstreq_status", oSTATUS, 0);
        check("rstreq_rdata", oRDATA, 0);
        check("rstreq_bus", {oBUS_WRITE, oBUS_ADDR, oBUS_WDATA}, 0);
        iCMD = 32'h0000_0099;
        m_tag = 1'b0; m_to = 1'b0; m_err = 1'b0; m_cnt = 8'd0; m_addr = '0; m_rdata = '0;
        tick(); tick();
        iRESET_N = 1'b1;
        nb = n_req;
        for (int n = 0; n < 20; n++) tick();
        check("post_rst_no_xfer", n_req, nb);
        check("post_rst_status", oSTATUS, 0);

        // Count wrap over 256 alternating-tag writes
        for (int i = 0; i < 256; i++) begin
            c = {~i[0], 1'b1, 14'h0, 16'(i)};
            drive_cmd(c, 32'(i * 3));
            wait_valid(7);
            finish_xfer(c, 0, 1'b0, 32'h0);
        end
        check("count_wrap", oSTATUS[WIDTH-5 -: 8], 8'h00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
